// File: rtl/pixel_line_fetcher.sv
// Line-ahead pixel fetcher: pulls each active line from the framebuffer into a
// two-bank line buffer and replays it one pixel per newpixel strobe.
module pixel_line_fetcher #(
  parameter int unsigned PIXELS_PER_LINE = 256,
  parameter int unsigned PIXEL_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH      = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   newframe,
  input  logic                   newpixel,
  input  logic                   visible_window,
  input  logic [8:0]             v_active,
  input  logic [ADDR_WIDTH-1:0]  fb_base,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ack,
  input  logic [PIXEL_WIDTH-1:0] mem_rdata,
  output logic [PIXEL_WIDTH-1:0] pixel,
  output logic                   pixel_valid,
  output logic                   underrun
);

  localparam int unsigned XW = (PIXELS_PER_LINE > 1) ? $clog2(PIXELS_PER_LINE) : 1;
  localparam int unsigned CW = 9 + XW;
  localparam logic [XW-1:0] X_LAST = XW'(PIXELS_PER_LINE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ABORT
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [ADDR_WIDTH-1:0]  nf_base_q, nf_base_d;
  logic [8:0]             fetch_line_q, fetch_line_d;
  logic [XW-1:0]          fetch_x_q, fetch_x_d;
  logic                   fetch_bank_q, fetch_bank_d;
  logic [1:0]             ready_q, ready_d;
  logic                   disp_bank_q, disp_bank_d;
  logic [8:0]             disp_line_q, disp_line_d;
  logic                   pending_q, pending_d;
  logic [8:0]             pend_line_q, pend_line_d;
  logic                   pend_bank_q, pend_bank_d;
  logic                   vis_q, vis_d;
  logic [XW-1:0]          rd_x_q, rd_x_d;
  logic                   line_ok_q, line_ok_d;
  logic [PIXEL_WIDTH-1:0] pixel_q, pixel_d;
  logic                   pixel_valid_q, pixel_valid_d;
  logic                   underrun_q, underrun_d;

  logic [PIXEL_WIDTH-1:0] line_mem [2*PIXELS_PER_LINE];
  logic                   wr_en;
  logic [XW:0]            wr_idx;
  logic [CW-1:0]          line_off;

  logic                   win_open, line_end, restart, consume, fetch_done;
  logic                   cur_ok;
  logic [XW-1:0]          cur_x;
  logic [ADDR_WIDTH-1:0]  restart_base;

  assign line_off    = {fetch_line_q, fetch_x_q};
  assign mem_req     = (state_q != ST_IDLE);
  assign mem_addr    = base_q + ADDR_WIDTH'(line_off);
  assign pixel       = pixel_q;
  assign pixel_valid = pixel_valid_q;
  assign underrun    = underrun_q;

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    nf_base_d     = nf_base_q;
    fetch_line_d  = fetch_line_q;
    fetch_x_d     = fetch_x_q;
    fetch_bank_d  = fetch_bank_q;
    ready_d       = ready_q;
    disp_bank_d   = disp_bank_q;
    disp_line_d   = disp_line_q;
    pending_d     = pending_q;
    pend_line_d   = pend_line_q;
    pend_bank_d   = pend_bank_q;
    vis_d         = visible_window;
    rd_x_d        = rd_x_q;
    line_ok_d     = line_ok_q;
    pixel_d       = '0;
    pixel_valid_d = 1'b0;
    underrun_d    = underrun_q;
    wr_en         = 1'b0;
    wr_idx        = {fetch_bank_q, fetch_x_q};
    restart       = 1'b0;
    consume       = 1'b0;
    fetch_done    = 1'b0;
    restart_base  = newframe ? fb_base : nf_base_q;

    win_open = visible_window & ~vis_q;
    line_end = ~visible_window & vis_q & ~newframe;

    case (state_q)
      ST_IDLE: begin
        if (newframe) begin
          restart = 1'b1;
        end else if (pending_q) begin
          consume      = 1'b1;
          pending_d    = 1'b0;
          state_d      = ST_FETCH;
          fetch_line_d = pend_line_q;
          fetch_bank_d = pend_bank_q;
          fetch_x_d    = '0;
        end
      end
      ST_FETCH: begin
        if (newframe) begin
          // A same-cycle ack completes the outstanding beat, so restart at once.
          nf_base_d = fb_base;
          if (mem_ack) restart = 1'b1;
          else         state_d = ST_ABORT;
        end else if (mem_ack) begin
          wr_en = 1'b1;
          if (fetch_x_q == X_LAST) begin
            fetch_done = 1'b1;
            fetch_x_d  = '0;
            state_d    = ST_IDLE;
          end else begin
            fetch_x_d = fetch_x_q + 1'b1;
          end
        end
      end
      ST_ABORT: begin
        if (newframe) nf_base_d = fb_base;
        if (mem_ack)  restart   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (line_end) begin
      ready_d[disp_bank_q] = 1'b0;
      disp_bank_d          = ~disp_bank_q;
      disp_line_d          = disp_line_q + 9'd1;
      if (({1'b0, disp_line_q} + 10'd2) < {1'b0, v_active}) begin
        if (pending_q && !consume) begin
          underrun_d = 1'b1;
        end else begin
          pending_d   = 1'b1;
          pend_line_d = disp_line_q + 9'd2;
          pend_bank_d = disp_bank_q;
        end
      end
    end

    if (fetch_done) ready_d[fetch_bank_q] = 1'b1;

    if (restart) begin
      base_d       = restart_base;
      ready_d      = '0;
      disp_bank_d  = 1'b0;
      disp_line_d  = '0;
      fetch_line_d = '0;
      fetch_bank_d = 1'b0;
      fetch_x_d    = '0;
      pending_d    = 1'b0;
      state_d      = ST_IDLE;
      if (v_active != 9'd0) begin
        state_d = ST_FETCH;
        if (v_active != 9'd1) begin
          pending_d   = 1'b1;
          pend_line_d = 9'd1;
          pend_bank_d = 1'b1;
        end
      end
    end

    cur_ok = win_open ? ready_q[disp_bank_q] : line_ok_q;
    cur_x  = win_open ? '0 : rd_x_q;
    if (win_open) begin
      line_ok_d = ready_q[disp_bank_q];
      rd_x_d    = '0;
      if (!ready_q[disp_bank_q]) underrun_d = 1'b1;
    end
    if (visible_window && newpixel) begin
      pixel_valid_d = 1'b1;
      pixel_d       = cur_ok ? line_mem[{disp_bank_q, cur_x}] : '0;
      if (cur_x != X_LAST) rd_x_d = cur_x + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) line_mem[wr_idx] <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      nf_base_q     <= '0;
      fetch_line_q  <= '0;
      fetch_x_q     <= '0;
      fetch_bank_q  <= 1'b0;
      ready_q       <= '0;
      disp_bank_q   <= 1'b0;
      disp_line_q   <= '0;
      pending_q     <= 1'b0;
      pend_line_q   <= '0;
      pend_bank_q   <= 1'b0;
      vis_q         <= 1'b0;
      rd_x_q        <= '0;
      line_ok_q     <= 1'b0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      nf_base_q     <= nf_base_d;
      fetch_line_q  <= fetch_line_d;
      fetch_x_q     <= fetch_x_d;
      fetch_bank_q  <= fetch_bank_d;
      ready_q       <= ready_d;
      disp_bank_q   <= disp_bank_d;
      disp_line_q   <= disp_line_d;
      pending_q     <= pending_d;
      pend_line_q   <= pend_line_d;
      pend_bank_q   <= pend_bank_d;
      vis_q         <= vis_d;
      rd_x_q        <= rd_x_d;
      line_ok_q     <= line_ok_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
      underrun_q    <= underrun_d;
    end
  end

endmodule
